bhist_checkpoint_ctrl: RTL

Sequencer for the global branch-history shift register. Accepts front-end predictions and tags each one with a checkpoint of the history value it was predicted under; forwards accepted predictions to the shift register's predict port. Back-end resolutions arrive in program order; on a mispredict the block drives the shift register's train port with the restored history, flushes all younger checkpoints, and blocks new predictions for one recovery cycle.

---
 rtl/bhist_pkg.sv | 19 +
 rtl/bhist_checkpoint_ctrl_if.sv | 39 +++
 rtl/bhist_ckpt_ram.sv | 25 ++
 rtl/bhist_checkpoint_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/bhist_pkg.sv
// Shared types for the branch-history checkpoint sequencer.
// Checkpoint layout and FSM encoding live here.
package bhist_pkg;

  localparam int HIST_W = 32;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

  typedef struct packed {
    logic [HIST_W-1:0] history;
    logic              taken;
  } checkpoint_t;

endpackage

// File: rtl/bhist_checkpoint_ctrl_if.sv
// Front-end request and back-end resolve bundle.
// master = predictor/back-end side, slave = sequencer.
interface bhist_checkpoint_ctrl_if #(
  parameter int TAG_W = 3
);

  logic             fe_valid;
  logic             fe_taken;
  logic             fe_ready;
  logic [TAG_W-1:0] fe_tag;

  logic             rs_valid;
  logic [TAG_W-1:0] rs_tag;
  logic             rs_taken;
  logic             rs_mispredicted;

  modport master (
    output fe_valid,
    output fe_taken,
    input  fe_ready,
    input  fe_tag,
    output rs_valid,
    output rs_tag,
    output rs_taken,
    output rs_mispredicted
  );

  modport slave (
    input  fe_valid,
    input  fe_taken,
    output fe_ready,
    output fe_tag,
    input  rs_valid,
    input  rs_tag,
    input  rs_taken,
    input  rs_mispredicted
  );

endinterface

// File: rtl/bhist_ckpt_ram.sv
// Checkpoint storage: one write port, one async read port.
// Storage is not reset; occupancy tracks validity.
module bhist_ckpt_ram
  import bhist_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [TAG_W-1:0] waddr_i,
  input  checkpoint_t      wdata_i,
  input  logic [TAG_W-1:0] raddr_i,
  output checkpoint_t      rdata_o
);

  checkpoint_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bhist_checkpoint_ctrl.sv
// Global branch-history sequencer: checkpoints each prediction,
// restores history on mispredict and flushes younger entries.
module bhist_checkpoint_ctrl
  import bhist_pkg::*;
#(
  parameter int DEPTH = bhist_pkg::DEPTH,
  parameter int TAG_W = bhist_pkg::TAG_W
) (
  input  logic                   clk,
  input  logic                   reset,
  bhist_checkpoint_ctrl_if.slave io,
  input  logic [HIST_W-1:0]      cur_history,
  output logic                   sr_predict_valid,
  output logic                   sr_predict_taken,
  output logic                   sr_train_mispredicted,
  output logic                   sr_train_taken,
  output logic [HIST_W-1:0]      sr_train_history,
  output logic [TAG_W:0]         occupancy,
  output logic                   err_sticky
);

  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   OCC_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   OCC_FULL = (TAG_W+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [TAG_W-1:0] wr_q, wr_d;
  logic [TAG_W:0]   occ_q, occ_d;
  logic             err_q, err_d;

  logic        resolve_ok;
  logic        mis;
  logic        pop;
  logic        push;
  checkpoint_t head;
  checkpoint_t wdata;
  logic        unused_head_taken;

  assign resolve_ok = io.rs_valid && (occ_q != '0)
                   && (io.rs_tag == rd_q);
  assign mis  = resolve_ok && io.rs_mispredicted;
  assign pop  = resolve_ok && !io.rs_mispredicted;

  // Gating on reset keeps the shift register idle while reset is held.
  assign io.fe_ready = !reset && (state_q == RUN)
                    && (occ_q < OCC_FULL) && !mis;
  assign push      = io.fe_valid && io.fe_ready;
  assign io.fe_tag = wr_q;

  assign wdata.history = cur_history;
  assign wdata.taken   = io.fe_taken;

  bhist_ckpt_ram #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_q),
    .wdata_i (wdata),
    .raddr_i (rd_q),
    .rdata_o (head)
  );

  assign unused_head_taken = head.taken;

  assign sr_predict_valid      = push;
  assign sr_predict_taken      = push && io.fe_taken;
  assign sr_train_mispredicted = !reset && mis;
  assign sr_train_taken        = !reset && mis && io.rs_taken;
  assign sr_train_history      = (!reset && mis) ? head.history : '0;

  assign occupancy  = occ_q;
  assign err_sticky = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    occ_d   = occ_q;
    err_d   = err_q | (io.rs_valid && !resolve_ok);
    unique case (state_q)
      RUN:     state_d = mis ? RECOVER : RUN;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase
    if (push) wr_d = wr_q + PTR_ONE;
    if (pop)  rd_d = rd_q + PTR_ONE;
    unique case (1'b1)
      mis:          occ_d = '0;
      push && !pop: occ_d = occ_q + OCC_ONE;
      pop && !push: occ_d = occ_q - OCC_ONE;
      default:      occ_d = occ_q;
    endcase
    // A flush drops every younger checkpoint at once.
    if (mis) rd_d = wr_q;
  end

endmodule
